// File: rtl/syscall_print_ctrl.sv
// syscall_print_ctrl
// Sequences the syscall path of the single-cycle core. print_int and
// print_string stall the PC while items stream to the console sink over
// valid/ready. For strings the controller borrows the data-memory read port
// and walks bytes little-endian within each word. exit parks the core in a
// sticky halt.
module syscall_print_ctrl #(
  parameter int unsigned MAX_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        mem_sel,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        out_valid,
  output logic        out_is_int,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        halted,
  output logic        trunc,
  output logic [31:0] char_count
);

  localparam logic [31:0] LP_MAX_LEN = 32'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_INT   = 3'd4,
    S_DONE  = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_ptr;
  logic [31:0] w_ptr_nxt;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;
  logic [31:0] r_wbuf;
  logic [31:0] w_wbuf_nxt;
  logic [31:0] r_int;
  logic [31:0] w_int_nxt;
  logic        r_trunc;
  logic        w_trunc_nxt;
  logic [31:0] r_char_count;
  logic [31:0] w_char_count_nxt;

  logic [7:0]  w_byte;
  logic [31:0] w_ptr_inc;

  // Current string byte: lane ptr[1:0] of the buffered word.
  assign w_byte    = r_wbuf[{r_ptr[1:0], 3'b000} +: 8];
  assign w_ptr_inc = r_ptr + 32'd1;

  assign trunc      = r_trunc;
  assign char_count = r_char_count;

  // State and datapath registers; reset drops any in-flight item.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= 32'd0;
      r_cnt        <= 32'd0;
      r_wbuf       <= 32'd0;
      r_int        <= 32'd0;
      r_trunc      <= 1'b0;
      r_char_count <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_wbuf       <= w_wbuf_nxt;
      r_int        <= w_int_nxt;
      r_trunc      <= w_trunc_nxt;
      r_char_count <= w_char_count_nxt;
    end
  end

  // Next-state and output decode; stall is combinational so the PC holds
  // on the syscall's own edge.
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_cnt_nxt        = r_cnt;
    w_wbuf_nxt       = r_wbuf;
    w_int_nxt        = r_int;
    w_trunc_nxt      = r_trunc;
    w_char_count_nxt = r_char_count;
    mem_sel          = 1'b0;
    mem_addr         = 32'd0;
    stall            = 1'b0;
    out_valid        = 1'b0;
    out_is_int       = 1'b0;
    out_data         = 32'd0;
    halted           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (syscall) begin
          if (v0 == 32'd1) begin
            stall       = 1'b1;
            w_int_nxt   = a0;
            w_state_nxt = S_INT;
          end else if (v0 == 32'd4) begin
            stall       = 1'b1;
            w_ptr_nxt   = a0;
            w_cnt_nxt   = 32'd0;
            w_state_nxt = S_FETCH;
          end else if (v0 == 32'd10) begin
            stall       = 1'b1;
            halted      = 1'b1;
            w_state_nxt = S_HALT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_FETCH: begin
        stall       = 1'b1;
        mem_sel     = 1'b1;
        mem_addr    = {r_ptr[31:2], 2'b00};
        w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        stall       = 1'b1;
        mem_sel     = 1'b1;
        w_wbuf_nxt  = mem_rdata;
        w_state_nxt = S_EMIT;
      end

      S_EMIT: begin
        stall = 1'b1;
        if (w_byte == 8'd0) begin
          w_state_nxt = S_DONE;
        end else if (r_cnt == LP_MAX_LEN) begin
          // Unterminated string guard.
          w_trunc_nxt = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          out_valid  = 1'b1;
          out_is_int = 1'b0;
          out_data   = {24'd0, w_byte};
          if (out_ready) begin
            w_ptr_nxt        = w_ptr_inc;
            w_cnt_nxt        = r_cnt + 32'd1;
            w_char_count_nxt = r_char_count + 32'd1;
            if (w_ptr_inc[1:0] == 2'b00) begin
              w_state_nxt = S_FETCH;
            end else begin
              w_state_nxt = S_EMIT;
            end
          end else begin
            w_state_nxt = S_EMIT;
          end
        end
      end

      S_INT: begin
        stall      = 1'b1;
        out_valid  = 1'b1;
        out_is_int = 1'b1;
        out_data   = r_int;
        if (out_ready) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_INT;
        end
      end

      S_DONE: begin
        // One unstalled cycle lets the PC step past the syscall.
        w_state_nxt = S_IDLE;
      end

      S_HALT: begin
        stall       = 1'b1;
        halted      = 1'b1;
        w_state_nxt = S_HALT;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_syscall_print_ctrl.sv
// Directed bench for syscall_print_ctrl (instance built with MAX_LEN=4).
module tb_syscall_print_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        syscall;
  logic [31:0] v0;
  logic [31:0] a0;
  logic        mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'd0;
  logic        stall;
  logic        out_valid;
  logic        out_is_int;
  logic [31:0] out_data;
  logic        out_ready;
  logic        halted;
  logic        trunc;
  logic [31:0] char_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [31:0]];
  logic        prev_sel = 1'b0;
  int          fetch_cnt = 0;
  int          fetch_base;

  syscall_print_ctrl #(.MAX_LEN(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .syscall    (syscall),
    .v0         (v0),
    .a0         (a0),
    .mem_sel    (mem_sel),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .out_valid  (out_valid),
    .out_is_int (out_is_int),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .halted     (halted),
    .trunc      (trunc),
    .char_count (char_count)
  );

  always #5 clk = ~clk;

  // One-cycle synchronous read memory model.
  always @(posedge clk) begin
    if (mem_sel) begin
      mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'd0;
    end
  end

  // Count FETCH cycles as rising edges of mem_sel.
  always @(posedge clk) begin
    prev_sel <= mem_sel;
    if (mem_sel && !prev_sel) begin
      fetch_cnt <= fetch_cnt + 1;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes.
  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; syscall = 1'b0; v0 = 32'd0; a0 = 32'd0; out_ready = 1'b0;
    mem[32'h100] = 32'h000A6948;
    nxt(); nxt();
    reset = 1'b0;
    settle();
    chk_eq("rst_stall", {31'd0, stall}, 32'd0);
    chk_eq("rst_mem_sel", {31'd0, mem_sel}, 32'd0);
    chk_eq("rst_mem_addr", mem_addr, 32'd0);
    chk_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("rst_is_int", {31'd0, out_is_int}, 32'd0);
    chk_eq("rst_data", out_data, 32'd0);
    chk_eq("rst_halted", {31'd0, halted}, 32'd0);
    chk_eq("rst_trunc", {31'd0, trunc}, 32'd0);
    chk_eq("rst_chars", char_count, 32'd0);

    // print_int of -10 with the sink always ready.
    nxt();
    out_ready = 1'b1; syscall = 1'b1; v0 = 32'd1; a0 = 32'hFFFFFFF6;
    settle();
    chk_eq("int_sc_stall", {31'd0, stall}, 32'd1);
    chk_eq("int_sc_valid", {31'd0, out_valid}, 32'd0);
    nxt(); settle();
    chk_eq("int_stall", {31'd0, stall}, 32'd1);
    chk_eq("int_valid", {31'd0, out_valid}, 32'd1);
    chk_eq("int_is_int", {31'd0, out_is_int}, 32'd1);
    chk_eq("int_data", out_data, 32'hFFFFFFF6);
    nxt(); settle();
    chk_eq("int_done_stall", {31'd0, stall}, 32'd0);
    chk_eq("int_done_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("int_chars", char_count, 32'd0);
    syscall = 1'b0;
    nxt(); settle();
    chk_eq("int_idle_stall", {31'd0, stall}, 32'd0);

    // print_string "Hi\n" at 0x100.
    fetch_base = fetch_cnt;
    syscall = 1'b1; v0 = 32'd4; a0 = 32'h100;
    settle();
    chk_eq("hi_sc_stall", {31'd0, stall}, 32'd1);
    nxt(); settle();
    chk_eq("hi_fetch_sel", {31'd0, mem_sel}, 32'd1);
    chk_eq("hi_fetch_addr", mem_addr, 32'h100);
    nxt(); settle();
    chk_eq("hi_wait_sel", {31'd0, mem_sel}, 32'd1);
    chk_eq("hi_wait_valid", {31'd0, out_valid}, 32'd0);
    nxt(); settle();
    chk_eq("hi_c0_valid", {31'd0, out_valid}, 32'd1);
    chk_eq("hi_c0_is_int", {31'd0, out_is_int}, 32'd0);
    chk_eq("hi_c0", out_data, 32'h48);
    chk_eq("hi_c0_sel", {31'd0, mem_sel}, 32'd0);
    nxt(); settle();
    chk_eq("hi_c1", out_data, 32'h69);
    nxt(); settle();
    chk_eq("hi_c2", out_data, 32'h0A);
    nxt(); settle();
    chk_eq("hi_nul_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("hi_nul_stall", {31'd0, stall}, 32'd1);
    nxt(); settle();
    chk_eq("hi_done_stall", {31'd0, stall}, 32'd0);
    syscall = 1'b0;
    chk_eq("hi_chars", char_count, 32'd3);
    chk_eq("hi_fetches", 32'(fetch_cnt - fetch_base), 32'd1);
    nxt();

    // print_string "AB" at 0x103 crossing a word, sink toggling.
    mem[32'h100] = 32'h41000000;
    mem[32'h104] = 32'h00000042;
    syscall = 1'b1; v0 = 32'd4; a0 = 32'h103;
    settle();
    nxt(); settle();
    chk_eq("ab_fetch0", mem_addr, 32'h100);
    nxt(); nxt();
    out_ready = 1'b0; settle();
    chk_eq("ab_a_valid", {31'd0, out_valid}, 32'd1);
    chk_eq("ab_a", out_data, 32'h41);
    nxt(); out_ready = 1'b1; settle();
    chk_eq("ab_a_hold_valid", {31'd0, out_valid}, 32'd1);
    chk_eq("ab_a_hold", out_data, 32'h41);
    nxt(); out_ready = 1'b0; settle();
    chk_eq("ab_fetch1_sel", {31'd0, mem_sel}, 32'd1);
    chk_eq("ab_fetch1", mem_addr, 32'h104);
    chk_eq("ab_fetch1_valid", {31'd0, out_valid}, 32'd0);
    nxt(); out_ready = 1'b1; settle();
    nxt(); out_ready = 1'b0; settle();
    chk_eq("ab_b", out_data, 32'h42);
    chk_eq("ab_b_is_int", {31'd0, out_is_int}, 32'd0);
    nxt(); out_ready = 1'b1; settle();
    chk_eq("ab_b_hold", out_data, 32'h42);
    chk_eq("ab_b_hold_valid", {31'd0, out_valid}, 32'd1);
    nxt(); settle();
    chk_eq("ab_nul_valid", {31'd0, out_valid}, 32'd0);
    nxt(); settle();
    chk_eq("ab_done_stall", {31'd0, stall}, 32'd0);
    syscall = 1'b0;
    chk_eq("ab_chars", char_count, 32'd5);
    nxt();

    // Unterminated string against MAX_LEN=4.
    mem[32'h200] = 32'h44434241;
    mem[32'h204] = 32'h48474645;
    syscall = 1'b1; v0 = 32'd4; a0 = 32'h200;
    settle();
    nxt(); nxt(); nxt();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_eq($sformatf("tr_c%0d", i), out_data, 32'h41 + 32'(i));
      nxt();
    end
    settle();
    chk_eq("tr_fetch1", mem_addr, 32'h204);
    nxt(); nxt(); settle();
    chk_eq("tr_cap_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("tr_cap_stall", {31'd0, stall}, 32'd1);
    nxt(); settle();
    chk_eq("tr_trunc", {31'd0, trunc}, 32'd1);
    chk_eq("tr_done_stall", {31'd0, stall}, 32'd0);
    chk_eq("tr_chars", char_count, 32'd9);
    syscall = 1'b0;
    nxt();
    syscall = 1'b1; v0 = 32'd1; a0 = 32'h1234;
    settle();
    chk_eq("tr_next_stall", {31'd0, stall}, 32'd1);
    nxt(); settle();
    chk_eq("tr_next_data", out_data, 32'h1234);
    chk_eq("tr_next_is_int", {31'd0, out_is_int}, 32'd1);
    nxt(); settle();
    syscall = 1'b0;
    chk_eq("tr_sticky", {31'd0, trunc}, 32'd1);
    nxt();

    // Reset while a character is pending in EMIT.
    mem[32'h300] = 32'h00006261;
    out_ready = 1'b0;
    syscall = 1'b1; v0 = 32'd4; a0 = 32'h300;
    settle();
    nxt(); nxt(); nxt(); settle();
    chk_eq("rs_pending_valid", {31'd0, out_valid}, 32'd1);
    chk_eq("rs_pending_data", out_data, 32'h61);
    reset = 1'b1;
    nxt();
    reset = 1'b0; syscall = 1'b0; settle();
    chk_eq("rs_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("rs_stall", {31'd0, stall}, 32'd0);
    chk_eq("rs_mem_sel", {31'd0, mem_sel}, 32'd0);
    chk_eq("rs_trunc", {31'd0, trunc}, 32'd0);
    chk_eq("rs_chars", char_count, 32'd0);
    syscall = 1'b1; v0 = 32'd5; settle();
    chk_eq("rs_v5_stall", {31'd0, stall}, 32'd0);
    nxt(); settle();
    chk_eq("rs_v5_stall2", {31'd0, stall}, 32'd0);
    chk_eq("rs_v5_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("rs_v5_sel", {31'd0, mem_sel}, 32'd0);

    // exit: sticky halt, later syscalls ignored, reset clears.
    out_ready = 1'b1; v0 = 32'd10; settle();
    chk_eq("ex_sc_halted", {31'd0, halted}, 32'd1);
    chk_eq("ex_sc_stall", {31'd0, stall}, 32'd1);
    nxt(); v0 = 32'd1; a0 = 32'h55; settle();
    chk_eq("ex_halted", {31'd0, halted}, 32'd1);
    chk_eq("ex_stall", {31'd0, stall}, 32'd1);
    nxt(); v0 = 32'd4; settle();
    chk_eq("ex_ign_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("ex_ign_halted", {31'd0, halted}, 32'd1);
    nxt(); settle();
    chk_eq("ex_ign_sel", {31'd0, mem_sel}, 32'd0);
    chk_eq("ex_ign_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    nxt();
    reset = 1'b0; syscall = 1'b0; settle();
    chk_eq("ex_rst_halted", {31'd0, halted}, 32'd0);
    chk_eq("ex_rst_stall", {31'd0, stall}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
